// File: rtl/bist_pkg.sv
// Shared types and LFSR/MISR step functions for the BIST pattern engine.
// The step functions work on 32-bit containers masked to the real width.
package bist_pkg;

    localparam int PAT_IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] lfsr_next(
        input logic [31:0] s,
        input logic [31:0] taps,
        input int          w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return ((s << 1) | {31'd0, ^(s & taps)}) & mask;
    endfunction

    function automatic logic [31:0] misr_next(
        input logic [31:0] s,
        input logic [31:0] taps,
        input logic [31:0] d,
        input int          w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return lfsr_next(s, taps, w) ^ (d & mask);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Shift register with XOR feedback and data injection.
// data tied to zero gives a plain LFSR; driven by the CUT it is a MISR.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] TAPS = '0,
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic [W-1:0] state
);

    logic [W-1:0] step;

    assign step = W'(misr_next(32'(state), 32'(TAPS), 32'(data), W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (en) begin
            state <= step;
        end
    end

endmodule

// File: rtl/bist_pattern_engine.sv
// BIST engine: LFSR drives the CUT, MISR compacts its response,
// final signature compared against a golden value.
module bist_pattern_engine
    import bist_pkg::*;
#(
    parameter int               N_IN       = 7,
    parameter int               N_OUT      = 4,
    parameter int               PAT_CNT    = 255,
    parameter logic [N_IN-1:0]  LFSR_TAPS  = 7'b1100000,
    parameter logic [N_IN-1:0]  LFSR_SEED  = 7'b0000001,
    parameter logic [N_OUT-1:0] MISR_TAPS  = 4'b1001,
    parameter logic [N_OUT-1:0] MISR_SEED  = 4'b0000,
    parameter int               CUT_LAT    = 0,
    parameter logic [N_OUT-1:0] GOLDEN_SIG = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      cut_in,
    input  logic [N_OUT-1:0]     cut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_OUT-1:0]     signature,
    output logic [PAT_IDX_W-1:0] pat_idx
);

    localparam logic [N_IN-1:0] SEED =
        (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
    localparam logic [PAT_IDX_W-1:0] LAST_IDX = PAT_IDX_W'(PAT_CNT - 1);
    localparam logic [PAT_IDX_W-1:0] PAT_MAX  = PAT_IDX_W'(PAT_CNT);

    state_t            state;
    state_t            state_nxt;
    logic              issue;
    logic              last;
    logic              go;
    logic              absorb;
    logic              drain_end;
    logic              gen_en;
    logic              misr_en;
    logic              armed;
    logic [N_IN-1:0]   lfsr;
    logic [N_OUT-1:0]  sig_step;

    assign issue   = (state == RUN);
    assign last    = issue && (pat_idx == LAST_IDX);
    assign go      = start && !abort && (state == IDLE || state == DONE);
    assign gen_en  = issue && !last && !abort;
    assign misr_en = absorb && !abort;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // cut_in stays 0 from reset until the first run; afterwards it holds the LFSR
    assign cut_in = lfsr & {N_IN{armed}};

    assign sig_step = N_OUT'(misr_next(32'(signature), 32'(MISR_TAPS),
                                       32'(cut_out), N_OUT));

    bist_lfsr #(
        .W    (N_IN),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (gen_en),
        .load  (go),
        .data  ('0),
        .state (lfsr)
    );

    bist_lfsr #(
        .W    (N_OUT),
        .TAPS (MISR_TAPS),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .en    (misr_en),
        .load  (go),
        .data  (cut_out),
        .state (signature)
    );

    generate
        if (CUT_LAT == 0) begin : g_nolat
            assign absorb    = issue;
            assign drain_end = 1'b1;
        end else begin : g_lat
            localparam logic [CUT_LAT-1:0] TAIL = CUT_LAT'(1) << (CUT_LAT - 1);
            logic [CUT_LAT-1:0] vld;

            always_ff @(posedge clk) begin
                if (rst || abort) begin
                    vld <= '0;
                end else begin
                    vld <= CUT_LAT'({vld, issue});
                end
            end

            assign absorb = vld[CUT_LAT-1];
            // issues are contiguous, so only the last pattern left means drained
            assign drain_end = (vld == TAIL);
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) state_nxt = RUN;
                RUN:        if (last) state_nxt = (CUT_LAT == 0) ? DONE : DRAIN;
                DRAIN:      if (drain_end) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_idx <= '0;
            pass    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                armed <= 1'b1;
            end
            if (abort || go) begin
                pass <= 1'b0;
            end else if (state_nxt == DONE && state != DONE) begin
                pass <= (sig_step == GOLDEN_SIG);
            end
            if (go) begin
                pat_idx <= '0;
            end else if (issue && !abort && pat_idx != PAT_MAX) begin
                pat_idx <= pat_idx + PAT_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Directed bench for bist_pattern_engine: small 3-bit instances for exact
// sequences and latency, default-sized instance for abort and reset.
module tb_bist_pattern_engine;

    logic clk;
    logic rst;
    logic st_g;
    logic ab_g;
    logic rst_e;
    logic st_e;
    logic ab_e;

    int n_tot  = 0;
    int n_pass = 0;

    logic [2:0]  cin_a, sig_a, cin_b, sig_b, cin_c, sig_c, cout_c, cin_d, sig_d;
    logic [15:0] idx_a, idx_b, idx_c, idx_d, idx_e;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic        busy_c, done_c, pass_c, busy_d, done_d, pass_d;
    logic [6:0]  cin_e;
    logic [3:0]  sig_e;
    logic        busy_e, done_e, pass_e;
    logic [2:0]  p1, p2;

    bist_pattern_engine #(
        .N_IN(3), .N_OUT(3), .PAT_CNT(7), .LFSR_TAPS(3'b110),
        .LFSR_SEED(3'b001), .MISR_TAPS(3'b110), .MISR_SEED(3'b000),
        .CUT_LAT(0), .GOLDEN_SIG(3'b100)
    ) u_a (
        .clk(clk), .rst(rst), .start(st_g), .abort(ab_g),
        .cut_in(cin_a), .cut_out(cin_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .pat_idx(idx_a)
    );

    bist_pattern_engine #(
        .N_IN(3), .N_OUT(3), .PAT_CNT(7), .LFSR_TAPS(3'b110),
        .LFSR_SEED(3'b001), .MISR_TAPS(3'b110), .MISR_SEED(3'b000),
        .CUT_LAT(0), .GOLDEN_SIG(3'b101)
    ) u_b (
        .clk(clk), .rst(rst), .start(st_g), .abort(ab_g),
        .cut_in(cin_b), .cut_out(cin_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .pat_idx(idx_b)
    );

    bist_pattern_engine #(
        .N_IN(3), .N_OUT(3), .PAT_CNT(7), .LFSR_TAPS(3'b110),
        .LFSR_SEED(3'b001), .MISR_TAPS(3'b110), .MISR_SEED(3'b000),
        .CUT_LAT(2), .GOLDEN_SIG(3'b100)
    ) u_c (
        .clk(clk), .rst(rst), .start(st_g), .abort(ab_g),
        .cut_in(cin_c), .cut_out(cout_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c), .pat_idx(idx_c)
    );

    bist_pattern_engine #(
        .N_IN(3), .N_OUT(3), .PAT_CNT(1), .LFSR_TAPS(3'b110),
        .LFSR_SEED(3'b000), .MISR_TAPS(3'b110), .MISR_SEED(3'b000),
        .CUT_LAT(0), .GOLDEN_SIG(3'b001)
    ) u_d (
        .clk(clk), .rst(rst), .start(st_g), .abort(ab_g),
        .cut_in(cin_d), .cut_out(cin_d), .busy(busy_d), .done(done_d),
        .pass(pass_d), .signature(sig_d), .pat_idx(idx_d)
    );

    bist_pattern_engine u_e (
        .clk(clk), .rst(rst_e), .start(st_e), .abort(ab_e),
        .cut_in(cin_e), .cut_out(cin_e[3:0]), .busy(busy_e), .done(done_e),
        .pass(pass_e), .signature(sig_e), .pat_idx(idx_e)
    );

    // two-flop CUT model feeding the CUT_LAT=2 instance
    always_ff @(posedge clk) begin
        p1 <= cin_c;
        p2 <= p1;
    end
    assign cout_c = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] idx;
        logic [2:0]  cin;
        logic [2:0]  sig;
        logic        busy;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    initial begin
        // LFSR 110/001 -> 001 010 101 011 111 110 100; MISR 110 over same data
        tbl[0] = '{16'd0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'd1, 3'b010, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'd2, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{16'd3, 3'b011, 3'b101, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'd4, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'd5, 3'b110, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'd6, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{16'd7, 3'b100, 3'b100, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; rst_e = 1'b1;
        st_g = 1'b0; ab_g = 1'b0; st_e = 1'b0; ab_e = 1'b0;
        step(); step();
        chk("rst.cin_a", cin_a, 0);
        chk("rst.sig_a", sig_a, 0);
        chk("rst.idx_a", idx_a, 0);
        chk("rst.flags_a", {busy_a, done_a, pass_a}, 0);
        chk("rst.cin_e", cin_e, 0);
        chk("rst.sig_e", sig_e, 0);
        rst = 1'b0; rst_e = 1'b0;
        step();

        st_g = 1'b1;
        step();
        st_g = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk($sformatf("a%0d.idx", k), idx_a, tbl[k].idx);
            chk($sformatf("a%0d.cin", k), cin_a, tbl[k].cin);
            chk($sformatf("a%0d.sig", k), sig_a, tbl[k].sig);
            chk($sformatf("a%0d.busy", k), busy_a, tbl[k].busy);
            chk($sformatf("a%0d.done", k), done_a, tbl[k].done);
            chk($sformatf("a%0d.pass", k), pass_a, tbl[k].pass);
            if (k < 7) begin
                chk($sformatf("c%0d.cin", k), cin_c, tbl[k].cin);
                chk($sformatf("c%0d.busy", k), busy_c, 1);
            end
            if (k == 0) begin
                chk("d0.cin", cin_d, 3'b001);
                chk("d0.busy", busy_d, 1);
            end
            if (k == 1) begin
                chk("d1.done", done_d, 1);
                chk("d1.busy", busy_d, 0);
                chk("d1.cin", cin_d, 3'b001);
                chk("d1.sig", sig_d, 3'b001);
                chk("d1.idx", idx_d, 1);
                chk("d1.pass", pass_d, 1);
            end
        end
        chk("b.done", done_b, 1);
        chk("b.sig", sig_b, 3'b100);
        chk("b.pass", pass_b, 0);
        chk("c7.done", done_c, 0);
        chk("c7.cin_held", cin_c, 3'b100);
        step();
        chk("c8.done", done_c, 0);
        chk("c8.busy", busy_c, 1);
        step();
        chk("c9.done", done_c, 1);
        chk("c9.sig", sig_c, 3'b100);
        chk("c9.pass", pass_c, 1);
        chk("c9.idx", idx_c, 7);

        st_g = 1'b1; ab_g = 1'b1;
        step();
        st_g = 1'b0; ab_g = 1'b0;
        chk("a.startabort.done", done_a, 0);
        chk("a.startabort.busy", busy_a, 0);
        chk("a.startabort.pass", pass_a, 0);
        chk("a.startabort.sig", sig_a, 3'b100);

        st_e = 1'b1;
        step();
        st_e = 1'b0;
        chk("e0.idx", idx_e, 0);
        chk("e0.cin", cin_e, 7'h01);
        step(); step(); step();
        chk("e3.idx", idx_e, 3);
        chk("e3.cin", cin_e, 7'h08);
        chk("e3.sig", sig_e, 4'b0111);
        ab_e = 1'b1;
        step();
        ab_e = 1'b0;
        chk("e.abort.busy", busy_e, 0);
        chk("e.abort.done", done_e, 0);
        chk("e.abort.sig", sig_e, 4'b0111);

        st_e = 1'b1;
        step();
        st_e = 1'b0;
        chk("e.re0.idx", idx_e, 0);
        chk("e.re0.cin", cin_e, 7'h01);
        chk("e.re0.sig", sig_e, 4'b0000);
        step(); step(); step();
        chk("e.re3.idx", idx_e, 3);
        chk("e.re3.cin", cin_e, 7'h08);
        chk("e.re3.sig", sig_e, 4'b0111);

        repeat (47) step();
        chk("e50.idx", idx_e, 50);
        st_e = 1'b1;
        step();
        st_e = 1'b0;
        chk("e.busystart.idx", idx_e, 51);
        chk("e.busystart.busy", busy_e, 1);
        repeat (49) step();
        chk("e100.idx", idx_e, 100);
        rst_e = 1'b1;
        step();
        rst_e = 1'b0;
        chk("e.rst.cin", cin_e, 0);
        chk("e.rst.sig", sig_e, 0);
        chk("e.rst.idx", idx_e, 0);
        chk("e.rst.flags", {busy_e, done_e, pass_e}, 0);

        st_e = 1'b1; ab_e = 1'b1;
        step();
        st_e = 1'b0; ab_e = 1'b0;
        chk("e.startabort.busy", busy_e, 0);
        chk("e.startabort.idx", idx_e, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
